// File: rtl/sipo_pkg.sv
// Shared types and constants for the serial-in/parallel-out deserializer.
// The SIPO_PARITY_EN build uses the PARITY state; the default build only uses COLLECT.
package sipo_pkg;

  // FSM state encodings, kept as plain constants so they fit a 1-bit state register
  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] PARITY  = 1'b1;

  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/sipo_deserializer_if.sv
// Parallel valid/ready word port between the deserializer (master) and its consumer (slave).
interface sipo_deserializer_if #(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0] par_out;
  logic             par_valid;
  logic             par_ready;

  modport master (
    output par_out,
    output par_valid,
    input  par_ready
  );

  modport slave (
    input  par_out,
    input  par_valid,
    output par_ready
  );

endinterface

// File: rtl/sipo_deserializer_shift_core.sv
// Serial shift register, bit counter and latched direction; flags the cycle a word completes.
// With SIPO_PARITY_EN defined, a PARITY state absorbs one extra bit after the data bits.
module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             dir,
  output logic             complete,
  output logic [WIDTH-1:0] word
);

  localparam int               CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_next;
  logic [CNT_W-1:0] bit_cnt;
  logic             dir_q;
  logic             dir_eff;
  logic             last_bit;
  logic             shift_en;

  // The first bit of a word uses the live dir input; later bits use the latched copy
  assign dir_eff  = (bit_cnt == '0) ? dir : dir_q;
  assign last_bit = (bit_cnt == LAST);

  always_comb begin
    if (dir_eff == DIR_LSB_FIRST) begin
      sreg_next = {ser_in, sreg[WIDTH-1:1]};
    end else begin
      sreg_next = {sreg[WIDTH-2:0], ser_in};
    end
  end

`ifdef SIPO_PARITY_EN
  logic [0:0] state;

  assign shift_en = ser_valid && (state == COLLECT);
  assign complete = ser_valid && (state == PARITY);
  assign word     = sreg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= COLLECT;
    end else if (shift_en && last_bit) begin
      state <= PARITY;
    end else if (complete) begin
      state <= COLLECT;
    end
  end
`else
  assign shift_en = ser_valid;
  assign complete = ser_valid && last_bit;
  assign word     = sreg_next;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg    <= '0;
      bit_cnt <= '0;
      dir_q   <= DIR_MSB_FIRST;
    end else if (shift_en) begin
      sreg    <= sreg_next;
      bit_cnt <= last_bit ? '0 : bit_cnt + CNT_W'(1);
      if (bit_cnt == '0) begin
        dir_q <= dir;
      end
    end
  end

endmodule

// File: rtl/sipo_deserializer.sv
// Deserializer top: output holding register, valid/ready handshake, sticky overrun.
// Define SIPO_PARITY_EN to expect an even-parity bit after each word and report parity_err.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ser_in,
  input  logic                ser_valid,
  input  logic                dir,
  sipo_deserializer_if.master bus,
  output logic                overrun,
  output logic                parity_err
);

  logic             complete;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] par_out_q;
  logic             par_valid_q;
  logic             load;

  sipo_shift_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .ser_in    (ser_in),
    .ser_valid (ser_valid),
    .dir       (dir),
    .complete  (complete),
    .word      (word)
  );

  // A finished word is only taken if the holding register is empty or being drained now
  assign load = complete && (!par_valid_q || bus.par_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      par_out_q   <= '0;
      par_valid_q <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (load) begin
        par_out_q   <= word;
        par_valid_q <= 1'b1;
      end else if (par_valid_q && bus.par_ready) begin
        par_valid_q <= 1'b0;
      end
      if (complete && !load) begin
        overrun <= 1'b1;
      end
    end
  end

`ifdef SIPO_PARITY_EN
  // ser_in carries the parity bit in the completion cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_err <= 1'b0;
    end else if (load) begin
      parity_err <= (^word) ^ ser_in;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  assign bus.par_out   = par_out_q;
  assign bus.par_valid = par_valid_q;

endmodule
